// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2**ADDR_W x DATA_W register file, two read ports, one write port.
// Registered reads with per-register valid bits and optional write-to-read bypass.
//
// Ports:
//   clk                    rising-edge clock
//   reset                  asynchronous active-high reset
//   write                  write enable
//   writenum               write address
//   data_in                write data
//   clear                  synchronous clear of all registers and valid bits
//   read_en_a, read_en_b   read enables
//   readnum_a, readnum_b   read addresses
//   data_out_a, data_out_b registered read data (held when read enable is low)
//   valid_a, valid_b       registered valid bit of the register read

module regfile_2r1w #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 3,
    parameter int                BYPASS    = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] writenum,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear,
    input  logic              read_en_a,
    input  logic              read_en_b,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    output logic              valid_a,
    output logic              valid_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  vld;

    logic              wr_eff;
    logic              hit_a;
    logic              hit_b;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic              rv_a;
    logic              rv_b;

    // A write on a clear edge is dropped, so it must not forward either.
    always_comb begin
        wr_eff = write && !clear;
        hit_a  = (BYPASS != 0) && wr_eff && (readnum_a == writenum);
        hit_b  = (BYPASS != 0) && wr_eff && (readnum_b == writenum);
        rd_a   = hit_a ? data_in : regs[readnum_a];
        rd_b   = hit_b ? data_in : regs[readnum_b];
        rv_a   = hit_a || vld[readnum_a];
        rv_b   = hit_b || vld[readnum_b];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RESET_VAL;
            end
            vld <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RESET_VAL;
            end
            vld <= '0;
        end else if (write) begin
            regs[writenum] <= data_in;
            vld[writenum]  <= 1'b1;
        end
    end

    // Read ports sample pre-edge storage (or bypassed data), so a read
    // on a clear edge still returns the pre-clear contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_a <= RESET_VAL;
            valid_a    <= 1'b0;
        end else if (read_en_a) begin
            data_out_a <= rd_a;
            valid_a    <= rv_a;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_b <= RESET_VAL;
            valid_b    <= 1'b0;
        end else if (read_en_b) begin
            data_out_b <= rd_b;
            valid_b    <= rv_b;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: random and directed checks of regfile_2r1w against
// an array-based reference model, with bypass on and off, plus a 32x16 variant.

module tb_regfile_2r1w;

    logic        clk;
    logic        reset;
    logic        write;
    logic [2:0]  writenum;
    logic [15:0] data_in;
    logic        clear;
    logic        read_en_a;
    logic        read_en_b;
    logic [2:0]  readnum_a;
    logic [2:0]  readnum_b;

    logic [15:0] q1_a, q1_b, q0_a, q0_b;
    logic        v1_a, v1_b, v0_a, v0_b;

    logic        w_write;
    logic [3:0]  w_writenum;
    logic [31:0] w_data_in;
    logic        w_rea, w_reb;
    logic [3:0]  w_ra, w_rb;
    logic [31:0] w_qa, w_qb;
    logic        w_va, w_vb;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model
    logic [15:0] m_mem [8];
    bit          m_vld [8];
    logic [15:0] e1_a, e1_b, e0_a, e0_b;
    bit          ev1_a, ev1_b, ev0_a, ev0_b;

    regfile_2r1w #(.BYPASS(1)) dut_byp (
        .clk(clk), .reset(reset), .write(write), .writenum(writenum),
        .data_in(data_in), .clear(clear),
        .read_en_a(read_en_a), .read_en_b(read_en_b),
        .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(q1_a), .data_out_b(q1_b),
        .valid_a(v1_a), .valid_b(v1_b)
    );

    regfile_2r1w #(.BYPASS(0)) dut_nob (
        .clk(clk), .reset(reset), .write(write), .writenum(writenum),
        .data_in(data_in), .clear(clear),
        .read_en_a(read_en_a), .read_en_b(read_en_b),
        .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(q0_a), .data_out_b(q0_b),
        .valid_a(v0_a), .valid_b(v0_b)
    );

    regfile_2r1w #(.DATA_W(32), .ADDR_W(4)) dut_wide (
        .clk(clk), .reset(reset), .write(w_write), .writenum(w_writenum),
        .data_in(w_data_in), .clear(1'b0),
        .read_en_a(w_rea), .read_en_b(w_reb),
        .readnum_a(w_ra), .readnum_b(w_rb),
        .data_out_a(w_qa), .data_out_b(w_qb),
        .valid_a(w_va), .valid_b(w_vb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_mem[i] = '0;
            m_vld[i] = 1'b0;
        end
        e1_a = '0; e1_b = '0; e0_a = '0; e0_b = '0;
        ev1_a = 0; ev1_b = 0; ev0_a = 0; ev0_b = 0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, " byp_a"},  32'(q1_a), 32'(e1_a));
        chk({tag, " byp_b"},  32'(q1_b), 32'(e1_b));
        chk({tag, " byp_va"}, 32'(v1_a), 32'(ev1_a));
        chk({tag, " byp_vb"}, 32'(v1_b), 32'(ev1_b));
        chk({tag, " nob_a"},  32'(q0_a), 32'(e0_a));
        chk({tag, " nob_b"},  32'(q0_b), 32'(e0_b));
        chk({tag, " nob_va"}, 32'(v0_a), 32'(ev0_a));
        chk({tag, " nob_vb"}, 32'(v0_b), 32'(ev0_b));
    endtask

    task automatic idle();
        write = 0; writenum = '0; data_in = '0; clear = 0;
        read_en_a = 0; read_en_b = 0; readnum_a = '0; readnum_b = '0;
    endtask

    // One clock edge: drive, clock, update model from the rules, compare.
    task automatic step(input string tag, input bit w, input logic [2:0] wn,
                        input logic [15:0] d, input bit clr,
                        input bit rea, input logic [2:0] ra,
                        input bit reb, input logic [2:0] rb);
        bit fwd_a, fwd_b;
        write = w; writenum = wn; data_in = d; clear = clr;
        read_en_a = rea; readnum_a = ra;
        read_en_b = reb; readnum_b = rb;
        @(posedge clk);
        #1;
        fwd_a = w && !clr && (ra == wn);
        fwd_b = w && !clr && (rb == wn);
        if (rea) begin
            e0_a = m_mem[ra]; ev0_a = m_vld[ra];
            e1_a = fwd_a ? d : m_mem[ra];
            ev1_a = fwd_a ? 1'b1 : m_vld[ra];
        end
        if (reb) begin
            e0_b = m_mem[rb]; ev0_b = m_vld[rb];
            e1_b = fwd_b ? d : m_mem[rb];
            ev1_b = fwd_b ? 1'b1 : m_vld[rb];
        end
        if (clr) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[i] = '0;
                m_vld[i] = 1'b0;
            end
        end else if (w) begin
            m_mem[wn] = d;
            m_vld[wn] = 1'b1;
        end
        chk_all(tag);
    endtask

    // Reset pulse strictly between clock edges.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        model_reset();
        chk_all(tag);
        #1 reset = 1'b0;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        w_write = 0; w_writenum = '0; w_data_in = '0;
        w_rea = 0; w_reb = 0; w_ra = '0; w_rb = '0;
        model_reset();
        #12;
        chk_all("in_reset");
        @(negedge clk);
        reset = 1'b0;

        // reset read of regs 3 and 5
        step("rst_rd", 0, 0, 0, 0, 1, 3'd3, 1, 3'd5);
        chk("rst_rd_a_const", 32'(q1_a), 32'h0);
        chk("rst_rd_va_const", 32'(v1_a), 32'h0);

        // basic write/read and hold
        step("wr2", 1, 3'd2, 16'h8CFA, 0, 0, 0, 0, 0);
        step("wr3", 1, 3'd3, 16'hF080, 0, 0, 0, 0, 0);
        step("rd23", 0, 0, 0, 0, 1, 3'd2, 1, 3'd3);
        chk("rd2_const", 32'(q1_a), 32'h8CFA);
        chk("rd3_const", 32'(q1_b), 32'hF080);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1, 3'd2, 16'h1111, 0, 0, 3'd2, 0, 3'd3);
        end
        chk("hold_const", 32'(q1_a), 32'h8CFA);

        // same-edge write and read: forwarded vs. pre-edge
        step("byp4", 1, 3'd4, 16'h020F, 0, 1, 3'd4, 1, 3'd4);
        chk("byp4_on", 32'(q1_a), 32'h020F);
        chk("byp4_off", 32'(q0_a), 32'h0000);
        chk("byp4_off_v", 32'(v0_a), 32'h0);

        // clear beats write; read on clear edge sees pre-clear data
        step("wr5", 1, 3'd5, 16'hA800, 0, 0, 0, 0, 0);
        step("clr", 1, 3'd6, 16'h1234, 1, 1, 3'd5, 1, 3'd6);
        chk("clr_edge_rd5", 32'(q1_a), 32'hA800);
        step("aft_clr", 0, 0, 0, 0, 1, 3'd5, 1, 3'd6);
        chk("aft_clr5_v", 32'(v1_a), 32'h0);
        chk("aft_clr6", 32'(q1_b), 32'h0);

        // async reset mid-sequence
        step("wr1", 1, 3'd1, 16'h0002, 0, 0, 0, 0, 0);
        step("rd1", 0, 0, 0, 0, 1, 3'd1, 1, 3'd1);
        pulse_reset("mid_rst");
        step("rd1_aft", 0, 0, 0, 0, 1, 3'd1, 1, 3'd1);
        chk("rd1_aft_v", 32'(v1_a), 32'h0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (n % 137 == 136) begin
                pulse_reset("rnd_rst");
            end
            step("rnd",
                 ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
                 16'($urandom), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
        end

        // wide variant
        @(negedge clk);
        w_write = 1; w_writenum = 4'd15; w_data_in = 32'hDEADBEEF;
        w_rea = 1; w_ra = 4'd0; w_reb = 0;
        @(negedge clk);
        chk("wide_pre_v", 32'(w_va), 32'h0);
        w_writenum = 4'd0; w_data_in = 32'h00000001; w_rea = 0;
        @(negedge clk);
        w_write = 0; w_rea = 1; w_ra = 4'd15; w_reb = 1; w_rb = 4'd0;
        @(negedge clk);
        w_rea = 0; w_reb = 0;
        chk("wide_a", w_qa, 32'hDEADBEEF);
        chk("wide_b", w_qb, 32'h00000001);
        chk("wide_va", 32'(w_va), 32'h1);
        chk("wide_vb", 32'(w_vb), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width; depth = 2**ADDR_W registers.
REQ-003 SHALL have parameter BYPASS, default 1; 1 = write-to-read forwarding enabled, 0 = disabled.
REQ-004 SHALL have parameter RESET_VAL, default 0, DATA_W-bit value loaded into every register on reset or clear.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge except reset.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port write  input  1  write enable, sampled on the clk rising edge.
REQ-008 SHALL have port writenum  input  ADDR_W  write address.
REQ-009 SHALL have port data_in  input  DATA_W  write data.
REQ-010 SHALL have port clear  input  1  synchronous clear of all registers and valid bits.
REQ-011 SHALL have ports read_en_a, read_en_b  input  1 each  read enables for ports A and B.
REQ-012 SHALL have ports readnum_a, readnum_b  input  ADDR_W each  read addresses.
REQ-013 SHALL have ports data_out_a, data_out_b  output  DATA_W each  registered read data.
REQ-014 SHALL have ports valid_a, valid_b  output  1 each  registered flag: register read has been written since the last reset/clear.

Function
REQ-015 SHALL store 2**ADDR_W registers of DATA_W bits, each with one valid bit.
REQ-016 SHALL, on a rising edge with write=1 and clear=0, load data_in into register[writenum] and set its valid bit.
REQ-017 SHALL, on a rising edge with read_en_x=1, load data_out_x with register[readnum_x] and valid_x with its valid bit (1-cycle read latency).
REQ-018 SHALL hold data_out_x and valid_x unchanged on edges where read_en_x=0.
REQ-019 SHALL, when BYPASS=1, write=1, clear=0, read_en_x=1 and readnum_x==writenum on the same edge, load data_out_x with data_in and valid_x with 1.
REQ-020 SHALL, when BYPASS=0 under the same conditions, load data_out_x with the pre-edge register contents and valid bit.
REQ-021 SHALL serve both read ports independently; identical addresses on A and B return identical values.
REQ-022 SHALL, on a rising edge with clear=1, set every register to RESET_VAL and every valid bit to 0.
REQ-023 SHALL give clear priority over write: a write on a clear edge is discarded and no bypass occurs.
REQ-024 SHALL, for a read on a clear edge, return pre-clear contents and valid bit.
REQ-025 SHALL use all ADDR_W address bits; no address is out of range.

Reset
REQ-026 SHALL, while reset=1, immediately and asynchronously force all registers to RESET_VAL, all valid bits to 0, data_out_a/b to RESET_VAL, and valid_a/b to 0.
REQ-027 SHALL ignore write, clear and reads while reset=1; the first state update occurs on the first rising edge after reset deasserts.
REQ-028 SHALL, on reset asserted mid-sequence, lose all prior writes; a read after release returns RESET_VAL with valid 0.

Verification
REQ-029 Reset, then read A=3, B=5 -> data_out_a=data_out_b=0x0000, valid_a=valid_b=0.
REQ-030 Write 0x8CFA to reg 2 and 0xF080 to reg 3; next edge read A=2, B=3 -> 0x8CFA/0xF080, both valid=1; read_en low for 3 edges -> outputs held.
REQ-031 BYPASS=1: write 0x020F to reg 4 with read A=4 on the same edge -> data_out_a=0x020F, valid_a=1 after that edge. BYPASS=0: same stimulus -> 0x0000, valid_a=0.
REQ-032 Write 0xA800 to reg 5, then assert clear together with a write of 0x1234 to reg 6 -> next read of reg 5 = 0x0000 valid 0; reg 6 = 0x0000 valid 0.
REQ-033 Write 0x0002 to reg 1, pulse reset between clock edges -> outputs drop to 0x0000 without a clock edge; a later read of reg 1 = 0x0000, valid 0.
REQ-034 DATA_W=32, ADDR_W=4: write 0xDEADBEEF to reg 15 and 0x00000001 to reg 0; read A=15, B=0 -> 0xDEADBEEF/0x00000001, both valid=1.
